// File: rtl/osnt_replay_pkg.sv
// osnt_replay_pkg: trace entry layout, beat record and FSM state codes for the BRAM replay engine
// Entry layout: [511:0] tdata, [639:512] tuser, [767:640] tkeep, [768] tlast, [769] entry-valid
package osnt_replay_pkg;
  localparam int TDATA_W = 512;
  localparam int TUSER_W = 128;
  localparam int TKEEP_W = 128;
  localparam int ENTRY_W = 770;
  localparam int TLAST_BIT = 768;
  localparam int VALID_BIT = 769;
  // field order makes a beat_t bit-identical to entry bits [768:0]
  typedef struct packed {
    logic tlast;
    logic [TKEEP_W-1:0] tkeep;
    logic [TUSER_W-1:0] tuser;
    logic [TDATA_W-1:0] tdata;
  } beat_t;
  localparam int BEAT_W = $bits(beat_t);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
endpackage

// File: rtl/osnt_bram_replay_if.sv
// osnt_bram_replay_if: 512-bit AXI4-Stream beat channel from the replay engine to the TX path
// master: drives tdata/tuser/tkeep/tvalid/tlast, samples tready; slave: the reverse
interface osnt_bram_replay_if;
  import osnt_replay_pkg::*;
  logic [TDATA_W-1:0] tdata;
  logic [TUSER_W-1:0] tuser;
  logic [TKEEP_W-1:0] tkeep;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master(output tdata, tuser, tkeep, tvalid, tlast, input tready);
  modport slave(input tdata, tuser, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/osnt_replay_fifo2.sv
// osnt_replay_fifo2: two-entry first-word-fall-through beat buffer with occupancy output
// clk/rst_n: clock and async active-low reset; push/din: write; pop: consume head; dout: head; occ: 0..2
module osnt_replay_fifo2 import osnt_replay_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  beat_t din,
  input  logic pop,
  output beat_t dout,
  output logic [1:0] occ
);
  beat_t mem [2];
  logic wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  assign dout = mem[rp];
endmodule

// File: rtl/osnt_bram_replay.sv
// osnt_bram_replay: replays 770-bit trace BRAM entries as a 512-bit AXI4-Stream packet stream
// axis_aclk/axis_resetn: clock, async active-low reset; bram_*_b: BRAM port B read master;
// m_axis: output stream; replay_start/stop/count: control; replay_busy/done, pkt_count: status
module osnt_bram_replay import osnt_replay_pkg::*; #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = ENTRY_W
) (
  input  logic axis_aclk,
  input  logic axis_resetn,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  output logic bram_en_b,
  output logic [DATA_WIDTH/8-1:0] bram_we_b,
  output logic [DATA_WIDTH-1:0] bram_wrdata_b,
  input  logic [DATA_WIDTH-1:0] bram_rddata_b,
  osnt_bram_replay_if.master m_axis,
  input  logic replay_start,
  input  logic replay_stop,
  input  logic [31:0] replay_count,
  output logic replay_busy,
  output logic replay_done,
  output logic [31:0] pkt_count
);
  localparam int IDX_W = ADDR_WIDTH - 6;
  logic [1:0] state, occ;
  logic [IDX_W-1:0] word_idx, rd_idx;
  logic inflight, discard, stop_pending;
  logic [31:0] iter, count;
  logic pop, issue, ret, push, term, iter_end, stop_now, last_pkt, finish, drained;
  beat_t head;
  assign pop = m_axis.tvalid & m_axis.tready;
  // credit: buffer slots already promised (held + in flight, minus the one leaving now)
  assign issue = state == RUN && ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  // returns are only accepted in RUN, so reads issued on the way into DRAIN are dropped
  assign ret = state == RUN && inflight && !discard;
  assign term = ret && !bram_rddata_b[VALID_BIT];
  assign push = ret && bram_rddata_b[VALID_BIT];
  assign iter_end = term || (push && rd_idx == '1);
  assign stop_now = stop_pending || replay_stop;
  assign last_pkt = push && bram_rddata_b[TLAST_BIT] && stop_now;
  assign finish = last_pkt || (iter_end && (stop_now || (count != '0 && iter + 32'd1 == count)));
  assign drained = occ == 2'd0 && !inflight;
  always_ff @(posedge axis_aclk or negedge axis_resetn)
    if (!axis_resetn) begin
      state <= IDLE;
      word_idx <= '0;
      rd_idx <= '0;
      inflight <= 1'b0;
      discard <= 1'b0;
      stop_pending <= 1'b0;
      iter <= '0;
      count <= '0;
      pkt_count <= '0;
      replay_done <= 1'b0;
    end else begin
      replay_done <= state == DRAIN && drained;
      inflight <= issue;
      // the read issued alongside a terminator belongs to the dead iteration
      discard <= issue && term;
      if (issue) begin
        word_idx <= word_idx + 1'b1;
        rd_idx <= word_idx;
      end
      if (term) word_idx <= '0;
      if (pop && m_axis.tlast) pkt_count <= pkt_count + 32'd1;
      if (iter_end) iter <= iter + 32'd1;
      if (state == RUN && replay_stop) stop_pending <= 1'b1;
      if (state == IDLE && replay_start) begin
        state <= RUN;
        word_idx <= '0;
        iter <= '0;
        count <= replay_count;
        pkt_count <= '0;
        stop_pending <= 1'b0;
      end else if (state == RUN && finish) state <= DRAIN;
      else if (state == DRAIN && drained) state <= IDLE;
    end
  osnt_replay_fifo2 u_fifo (
    .clk(axis_aclk),
    .rst_n(axis_resetn),
    .push(push),
    .din(beat_t'(bram_rddata_b[BEAT_W-1:0])),
    .pop(pop),
    .dout(head),
    .occ(occ)
  );
  assign bram_en_b = issue;
  assign bram_addr_b = {word_idx, 6'b0};
  assign bram_we_b = '0;
  assign bram_wrdata_b = '0;
  assign replay_busy = state != IDLE;
  assign m_axis.tvalid = occ != 2'd0;
  assign m_axis.tlast = head.tlast;
  assign m_axis.tkeep = head.tkeep;
  assign m_axis.tuser = head.tuser;
  assign m_axis.tdata = head.tdata;
endmodule

// File: tb/tb_osnt_bram_replay.sv
// tb_osnt_bram_replay: scoreboard bench for the BRAM replay engine with a behavioural BRAM port B
module tb_osnt_bram_replay;
  import osnt_replay_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [19:0] addr;
  logic en;
  logic [95:0] we;
  logic [769:0] wrdata;
  logic [769:0] rddata;
  logic replay_start, replay_stop, busy, done;
  logic [31:0] replay_count, pkt_count;
  logic tready = 1'b1;
  logic rnd = 1'b0;
  logic [768:0] cur, held;
  logic stalled = 1'b0;
  logic [769:0] mem [16384];
  logic [768:0] exp_q [$];
  int beat_cyc [$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int d0, st_cyc, big;
  logic [769:0] e;
  osnt_bram_replay_if axis();
  osnt_bram_replay dut (
    .axis_aclk(clk),
    .axis_resetn(rstn),
    .bram_addr_b(addr),
    .bram_en_b(en),
    .bram_we_b(we),
    .bram_wrdata_b(wrdata),
    .bram_rddata_b(rddata),
    .m_axis(axis),
    .replay_start(replay_start),
    .replay_stop(replay_stop),
    .replay_count(replay_count),
    .replay_busy(busy),
    .replay_done(done),
    .pkt_count(pkt_count)
  );
  assign axis.tready = tready;
  assign cur = {axis.tlast, axis.tkeep, axis.tuser, axis.tdata};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (en) rddata <= mem[addr[19:6]];
  initial forever begin
    @(posedge clk);
    #1;
    tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  function automatic logic [769:0] ent(input int i, input bit last, input bit vld);
    logic [31:0] v;
    v = i;
    return {vld, last, {4{~v}}, {4{v * 32'd7}}, {16{v ^ 32'h5A5A_0000}}};
  endfunction
  task automatic check(input string nm, input logic [768:0] act, input logic [768:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // monitor: pops the scoreboard on every accepted beat and checks stall stability
  initial forever begin
    @(negedge clk);
    if (!rstn) stalled = 1'b0;
    else begin
      if (done) done_cnt++;
      if (stalled) begin
        check("hold_valid", axis.tvalid, 1);
        check("hold_payload", cur, held);
      end
      if (axis.tvalid && axis.tready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h want no beat", cur);
        end else check("beat", cur, exp_q.pop_front());
      end
      stalled = axis.tvalid && !axis.tready;
      held = cur;
    end
  end
  // 3 packets of 2,1,4 beats then a terminator at index 7
  task automatic load_trace();
    for (int i = 0; i < 7; i++) mem[i] = ent(i, i == 1 || i == 2 || i == 6, 1'b1);
    mem[7] = ent(7, 1'b0, 1'b0);
  endtask
  task automatic exp_trace(input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 7; i++) begin
        e = ent(i, i == 1 || i == 2 || i == 6, 1'b1);
        exp_q.push_back(e[768:0]);
      end
  endtask
  task automatic start(input logic [31:0] n);
    beat_cyc.delete();
    @(posedge clk);
    #1;
    replay_start = 1'b1;
    replay_count = n;
    st_cyc = cyc;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    replay_start = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    for (int n = 0; n < lim && done_cnt == d0; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_low", busy, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask
  task automatic wait_beats(input int k, input int lim);
    for (int n = 0; n < lim && beat_cyc.size() < k; n++) @(negedge clk);
    check("beats_reached", beat_cyc.size() >= k, 1);
  endtask
  initial begin
    replay_start = 1'b0;
    replay_stop = 1'b0;
    replay_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", axis.tvalid, 0);
    check("rst_payload", cur, 0);
    check("rst_en", en, 0);
    check("rst_addr", addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkt", pkt_count, 0);
    check("we_tied", we, 0);
    check("wrdata_tied", wrdata[768:0], 0);
    rstn = 1'b1;
    load_trace();
    exp_trace(1);
    start(1);
    wait_done(200);
    check("t1_latency", beat_cyc[0], st_cyc + 3);
    check("t1_beats", beat_cyc.size(), 7);
    check("t1_span", beat_cyc[$] - beat_cyc[0], 6);
    check("t1_pkts", pkt_count, 3);
    exp_trace(3);
    start(3);
    wait_done(400);
    big = 0;
    for (int i = 1; i < beat_cyc.size(); i++) if (beat_cyc[i] - beat_cyc[i-1] == 3) big++;
    check("t2_beats", beat_cyc.size(), 21);
    check("t2_gaps", big, 2);
    check("t2_span", beat_cyc[$] - beat_cyc[0], 24);
    check("t2_pkts", pkt_count, 9);
    rnd = 1'b1;
    exp_trace(2);
    start(2);
    wait_done(1000);
    rnd = 1'b0;
    check("t3_beats", beat_cyc.size(), 14);
    check("t3_pkts", pkt_count, 6);
    exp_trace(1);
    start(0);
    wait_beats(4, 200);
    @(posedge clk);
    #1;
    replay_stop = 1'b1;
    @(posedge clk);
    #1;
    replay_stop = 1'b0;
    wait_done(200);
    repeat (20) @(negedge clk);
    check("t4_beats", beat_cyc.size(), 7);
    check("t4_pkts", pkt_count, 3);
    exp_trace(1);
    start(0);
    wait_beats(2, 200);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("ar_valid", axis.tvalid, 0);
    check("ar_payload", cur, 0);
    check("ar_en", en, 0);
    check("ar_addr", addr, 0);
    check("ar_busy", busy, 0);
    check("ar_pkt", pkt_count, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("ar_no_beat", axis.tvalid, 0);
    exp_trace(1);
    start(1);
    wait_done(200);
    check("ar_latency", beat_cyc[0], st_cyc + 3);
    check("ar_beats", beat_cyc.size(), 7);
    check("ar_pkts", pkt_count, 3);
    for (int i = 0; i < 16384; i++) mem[i] = ent(i, i % 4 == 3, 1'b1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16384; i++) begin
        e = ent(i, i % 4 == 3, 1'b1);
        exp_q.push_back(e[768:0]);
      end
    start(2);
    wait_done(40000);
    check("full_beats", beat_cyc.size(), 32768);
    check("full_span", beat_cyc[$] - beat_cyc[0], 32767);
    check("full_pkts", pkt_count, 8192);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
